// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for the MIPS core: serialises data (LW/SW) and
// instruction-fetch accesses, data first, with a sticky RAM timeout flag.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              ihit,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dhit,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ready,
  output logic              err,
  output logic [2:0]        dbg_state
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] DACC = 3'd1;
  localparam logic [2:0] IACC = 3'd2;
  localparam logic [2:0] DONE = 3'd3;
  localparam logic [2:0] ERR  = 3'd4;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] store_q, store_d;
  logic              wr_q, wr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] iload_q, iload_d;
  logic [DATA_W-1:0] dload_q, dload_d;
  logic              ihit_q, ihit_d;
  logic              dhit_q, dhit_d;
  logic              err_q, err_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    store_d = store_q;
    wr_d    = wr_q;
    cnt_d   = cnt_q;
    iload_d = iload_q;
    dload_d = dload_q;
    ihit_d  = 1'b0;
    dhit_d  = 1'b0;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // Data wins so the current instruction's LW/SW finishes before the next fetch.
        if (dREN || dWEN) begin
          addr_d  = daddr;
          store_d = dstore;
          wr_d    = dWEN;
          state_d = DACC;
        end else if (iREN) begin
          addr_d  = iaddr;
          store_d = '0;
          wr_d    = 1'b0;
          state_d = IACC;
        end
      end
      DACC, IACC: begin
        cnt_d = cnt_q + 8'd1;
        if (ram_ready) begin
          if (state_q == IACC) begin
            iload_d = ramload;
            ihit_d  = 1'b1;
          end else begin
            if (!wr_q) dload_d = ramload;
            dhit_d = 1'b1;
          end
          state_d = DONE;
        end else if (cnt_q + 8'd1 == TIMEOUT_C) begin
          err_d   = 1'b1;
          state_d = ERR;
        end
      end
      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      store_q <= '0;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      iload_q <= '0;
      dload_q <= '0;
      ihit_q  <= 1'b0;
      dhit_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      store_q <= store_d;
      wr_q    <= wr_d;
      cnt_q   <= cnt_d;
      iload_q <= iload_d;
      dload_q <= dload_d;
      ihit_q  <= ihit_d;
      dhit_q  <= dhit_d;
      err_q   <= err_d;
    end
  end

  // RAM side is driven purely from latched request state, never from live inputs.
  assign ramREN    = (state_q == IACC) || ((state_q == DACC) && !wr_q);
  assign ramWEN    = (state_q == DACC) && wr_q;
  assign ramaddr   = ((state_q == IACC) || (state_q == DACC)) ? addr_q : '0;
  assign ramstore  = ramWEN ? store_q : '0;

  assign ihit      = ihit_q;
  assign dhit      = dhit_q;
  assign iload     = iload_q;
  assign dload     = dload_q;
  assign err       = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: the bench plays the RAM and both requesters, and
// predicts transaction order and returned data from a transaction-level model.
module tb_mem_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 4;
  localparam int TW      = 2 + ADDR_W + DATA_W;

  localparam logic [1:0] K_F  = 2'd0;
  localparam logic [1:0] K_RD = 2'd1;
  localparam logic [1:0] K_WR = 2'd2;
  localparam logic [2:0] ST_ERR = 3'd4;

  logic              CLK, RST;
  logic              iREN, ihit, dREN, dWEN, dhit;
  logic [ADDR_W-1:0] iaddr, daddr, ramaddr;
  logic [DATA_W-1:0] iload, dstore, dload, ramstore, ramload;
  logic              ramREN, ramWEN, ram_ready, err;
  logic [2:0]        dbg_state;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .ihit(ihit), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dhit(dhit), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready), .err(err), .dbg_state(dbg_state)
  );

  // Clock / watchdog
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: expected RAM transactions in order, plus expected held load values
  logic [TW-1:0]     exp_q[$];
  logic [DATA_W-1:0] model_iload, model_dload;
  int                n_checks = 0;
  int                n_pass   = 0;
  int                n_fail   = 0;
  int                last_wait;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic do_reset();
    RST = 1'b1;
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramload = '0; ram_ready = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    model_iload = '0;
    model_dload = '0;
    exp_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {ihit, dhit, ramREN, ramWEN, err}, 0);
    check({tag, "_iload"}, iload, 0);
    check({tag, "_dload"}, dload, 0);
    check({tag, "_ramaddr"}, ramaddr, 0);
    check({tag, "_ramstore"}, ramstore, 0);
  endtask

  // Raise requests; the model orders them data-first, both strobes high means write.
  task automatic issue(input bit do_f, input logic [ADDR_W-1:0] fa,
                       input bit do_d, input bit rd, input bit wr,
                       input logic [ADDR_W-1:0] da, input logic [DATA_W-1:0] ds);
    if (do_d) begin
      dREN = rd; dWEN = wr; daddr = da; dstore = ds;
      exp_q.push_back({wr ? K_WR : K_RD, da, wr ? ds : {DATA_W{1'b0}}});
    end
    if (do_f) begin
      iREN = 1'b1; iaddr = fa;
      exp_q.push_back({K_F, fa, {DATA_W{1'b0}}});
    end
  endtask

  // Act as the RAM for the next expected transaction: ready after 'delay' extra cycles.
  task automatic serve_one(input int delay, input logic [DATA_W-1:0] rdata, input bit mutate);
    logic [TW-1:0]     e;
    logic [1:0]        kind;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    int                w;
    check("exp_avail", exp_q.size() != 0, 1);
    if (exp_q.size() == 0) return;
    e    = exp_q.pop_front();
    kind = e[TW-1 -: 2];
    ea   = e[DATA_W +: ADDR_W];
    ed   = e[DATA_W-1:0];
    w = 0;
    while (!(ramREN || ramWEN) && w < 10) begin
      @(negedge CLK);
      w++;
    end
    last_wait = w;
    check("strobe_wait", w < 10, 1);
    if (w >= 10) return;
    for (int i = 0; i <= delay; i++) begin
      check("ram_en", {ramREN, ramWEN}, (kind == K_WR) ? 2'b01 : 2'b10);
      check("ramaddr", ramaddr, ea);
      if (kind == K_WR) check("ramstore", ramstore, ed);
      check("hit_during_acc", {ihit, dhit}, 0);
      if (mutate) begin
        if (kind == K_F) iaddr = iaddr + 4;
        else begin
          daddr  = daddr + 4;
          dstore = ~dstore;
        end
      end
      if (i == delay) begin
        ram_ready = 1'b1;
        ramload   = rdata;
      end else begin
        ramload = $urandom;
      end
      @(negedge CLK);
    end
    ram_ready = 1'b0;
    ramload   = $urandom;
    if (kind == K_F) begin
      check("ihit", {ihit, dhit}, 2'b10);
      model_iload = rdata;
      check("iload", iload, model_iload);
      iREN = 1'b0;
    end else begin
      check("dhit", {ihit, dhit}, 2'b01);
      if (kind == K_RD) model_dload = rdata;
      check("dload", dload, model_dload);
      dREN = 1'b0;
      dWEN = 1'b0;
    end
    check("strobe_in_done", {ramREN, ramWEN}, 0);
    @(negedge CLK);
    check("hit_pulse", {ihit, dhit}, 0);
    check("hold_iload", iload, model_iload);
    check("hold_dload", dload, model_dload);
  endtask

  initial begin
    int bad;
    @(negedge CLK);
    do_reset();
    check_all_zero("reset");

    // Fetch only, ready on the 2nd access cycle
    issue(1, 32'h0000_0040, 0, 0, 0, '0, '0);
    serve_one(1, 32'h2001_0005, 0);
    check("fetch_latency", last_wait, 1);

    // Simultaneous fetch and store: store must go first
    issue(1, 32'h44, 1, 0, 1, 32'h100, 32'hDEAD_BEEF);
    serve_one(0, $urandom, 0);
    serve_one(0, 32'hCAFE_0044, 0);

    // Load, ready on first access cycle: request, strobe, hit on consecutive cycles
    issue(0, '0, 1, 1, 0, 32'h200, '0);
    serve_one(0, 32'h1234_5678, 0);
    check("load_latency", last_wait, 1);

    // Address changes mid-access are ignored; ready on the last allowed cycle
    issue(0, '0, 1, 1, 0, 32'h300, '0);
    serve_one(TIMEOUT - 1, 32'h0BAD_F00D, 1);

    // ram_ready while idle is ignored
    ram_ready = 1'b1;
    ramload   = 32'hFFFF_FFFF;
    @(negedge CLK);
    ram_ready = 1'b0;
    @(negedge CLK);
    check("idle_ready_hits", {ihit, dhit, ramREN, ramWEN}, 0);
    check("idle_ready_iload", iload, model_iload);

    // Randomized mix of fetch / load / store / both-strobes / simultaneous
    for (int it = 0; it < 40; it++) begin
      int pat, op;
      bit rd, wr;
      pat = $urandom_range(0, 2);
      op  = $urandom_range(0, 2);
      rd  = (op != 1);
      wr  = (op != 0);
      issue(pat != 1, $urandom, pat != 0, rd, wr, $urandom, $urandom);
      while (exp_q.size() != 0) serve_one($urandom_range(0, TIMEOUT - 1), $urandom, $urandom_range(0, 1));
    end

    // Timeout: ram_ready never comes
    do_reset();
    iREN  = 1'b1;
    iaddr = 32'h80;
    @(negedge CLK);
    for (int i = 0; i < TIMEOUT; i++) begin
      check("to_ramREN", ramREN, 1);
      @(negedge CLK);
    end
    check("to_state", dbg_state, ST_ERR);
    check("to_err", err, 1);
    iREN = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (!err || ramREN || ramWEN || ihit || dhit) bad++;
      if (i == 5) begin
        dREN = 1'b1;
        ram_ready = 1'b1;
      end
      @(negedge CLK);
    end
    dREN = 1'b0;
    ram_ready = 1'b0;
    check("err_sticky", bad, 0);
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    model_iload = '0;
    model_dload = '0;
    check_all_zero("err_clear");

    // Reset mid-access: no strobe after reset edge, no hit
    dWEN = 1'b1; daddr = 32'h500; dstore = 32'h5555_AAAA;
    @(negedge CLK);
    check("mid_rst_pre", ramWEN, 1);
    @(negedge CLK);
    RST  = 1'b1;
    dWEN = 1'b0;
    @(negedge CLK);
    check("mid_rst_strobe", {ramREN, ramWEN}, 0);
    RST = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (dhit || ihit || ramWEN || ramREN) bad++;
      @(negedge CLK);
    end
    check("mid_rst_nohit", bad, 0);
    issue(1, 32'h600, 0, 0, 0, '0, '0);
    serve_one(1, 32'h7777_0600, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
